// File: rtl/clock_divider_bank_if.sv
// ============================================================================
//  Module   : clock_divider_bank_if
//  Brief    : Run-control, configuration handshake and divided-clock outputs
//             for the clock_divider_bank.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_divider_bank_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    ch_en;
  logic                 sync_in;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_ch;
  logic [DIV_WIDTH-1:0] cfg_period;
  logic [DIV_WIDTH-1:0] cfg_high;
  logic [NUM_CH-1:0]    div_clk;
  logic [NUM_CH-1:0]    tick;

  modport master (
    output ch_en, sync_in, cfg_valid, cfg_ch, cfg_period, cfg_high,
    input  cfg_ready, div_clk, tick
  );

  modport slave (
    input  ch_en, sync_in, cfg_valid, cfg_ch, cfg_period, cfg_high,
    output cfg_ready, div_clk, tick
  );
endinterface

`default_nettype wire

// File: rtl/clock_divider_bank.sv
// ============================================================================
//  Module   : clock_divider_bank
//  Brief    : NUM_CH programmable divided-clock generators with per-period
//             tick, phase-align and boundary-shadowed glitch-free reconfig.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_bank #(
  parameter int NUM_CH         = 4,
  parameter int DIV_WIDTH      = 16,
  parameter int DEFAULT_PERIOD = 100
) (
  input  wire logic           clk,
  input  wire logic           rst,
  clock_divider_bank_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SEL_N = 1 << CH_W;

  localparam logic [DIV_WIDTH-1:0] C_DEF_PERIOD = DIV_WIDTH'(DEFAULT_PERIOD);
  localparam logic [DIV_WIDTH-1:0] C_DEF_HIGH   = DIV_WIDTH'(DEFAULT_PERIOD / 2);
  localparam logic [DIV_WIDTH-1:0] C_ONE        = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] C_TWO        = DIV_WIDTH'(2);

  logic [NUM_CH-1:0] w_pending;
  logic [SEL_N-1:0]  w_pending_ext;

  // Unused select codes read as "not pending" so out-of-range writes are accepted.
  always_comb begin
    w_pending_ext               = '0;
    w_pending_ext[NUM_CH-1:0]   = w_pending;
  end

  assign bus.cfg_ready = ~w_pending_ext[bus.cfg_ch];

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_WIDTH-1:0] r_cnt;
      logic [DIV_WIDTH-1:0] r_period;
      logic [DIV_WIDTH-1:0] r_high;
      logic [DIV_WIDTH-1:0] r_sh_period;
      logic [DIV_WIDTH-1:0] r_sh_high;
      logic                 r_running;
      logic                 r_pending;
      logic                 r_div;
      logic                 r_tick;

      logic                 w_wr;
      logic [DIV_WIDTH-1:0] w_eff_period;
      logic                 w_boundary;
      logic                 w_apply;
      logic [DIV_WIDTH-1:0] w_cnt_next;
      logic [DIV_WIDTH-1:0] w_dec_high;

      assign w_wr         = bus.cfg_valid & bus.cfg_ready & (bus.cfg_ch == CH_W'(i));
      assign w_eff_period = (r_period < C_TWO) ? C_TWO : r_period;
      assign w_boundary   = ~r_running | bus.sync_in | (r_cnt == (w_eff_period - C_ONE));
      assign w_apply      = w_boundary & r_pending;
      assign w_cnt_next   = w_boundary ? '0 : (r_cnt + C_ONE);
      // A shadow applied on this edge already governs the new period's decode.
      assign w_dec_high   = w_apply ? r_sh_high : r_high;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt       <= '0;
          r_period    <= C_DEF_PERIOD;
          r_high      <= C_DEF_HIGH;
          r_sh_period <= C_DEF_PERIOD;
          r_sh_high   <= C_DEF_HIGH;
          r_running   <= 1'b0;
          r_pending   <= 1'b0;
          r_div       <= 1'b0;
          r_tick      <= 1'b0;
        end else if (!bus.ch_en[i]) begin
          r_running <= 1'b0;
          r_cnt     <= '0;
          r_div     <= 1'b0;
          r_tick    <= 1'b0;
          if (r_pending) begin
            r_period  <= r_sh_period;
            r_high    <= r_sh_high;
            r_pending <= 1'b0;
          end else if (w_wr) begin
            r_period <= bus.cfg_period;
            r_high   <= bus.cfg_high;
          end
        end else begin
          r_running <= 1'b1;
          r_cnt     <= w_cnt_next;
          r_div     <= (w_cnt_next < w_dec_high);
          r_tick    <= w_boundary;
          if (w_apply) begin
            r_period  <= r_sh_period;
            r_high    <= r_sh_high;
            r_pending <= 1'b0;
          end else if (w_wr) begin
            // A write landing on a wrap edge waits for the following boundary.
            if (r_running) begin
              r_sh_period <= bus.cfg_period;
              r_sh_high   <= bus.cfg_high;
              r_pending   <= 1'b1;
            end else begin
              r_period <= bus.cfg_period;
              r_high   <= bus.cfg_high;
            end
          end
        end
      end

      assign w_pending[i]   = r_pending;
      assign bus.div_clk[i] = r_div;
      assign bus.tick[i]    = r_tick;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
// ============================================================================
//  Module   : tb_clock_divider_bank
//  Brief    : Directed, table-driven self-checking bench for clock_divider_bank.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_bank;
  localparam int NCH = 6;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clock_divider_bank_if #(.NUM_CH(NCH), .DIV_WIDTH(DW)) bus ();

  clock_divider_bank #(
    .NUM_CH(NCH), .DIV_WIDTH(DW), .DEFAULT_PERIOD(100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           rst;
    logic [NCH-1:0] en;
    logic           sync;
    logic           vld;
    logic [2:0]     ch;
    logic [DW-1:0]  per;
    logic [DW-1:0]  hi;
    logic           e_rdy;
    logic [NCH-1:0] e_div;
    logic [NCH-1:0] e_tick;
  } vec_t;

  vec_t vq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic r, input logic [NCH-1:0] en, input logic s,
                              input logic v, input logic [2:0] ch, input int per,
                              input int hi, input logic rdy, input logic [NCH-1:0] d,
                              input logic [NCH-1:0] t);
    vec_t x;
    x.rst = r; x.en = en; x.sync = s; x.vld = v; x.ch = ch;
    x.per = DW'(per); x.hi = DW'(hi); x.e_rdy = rdy; x.e_div = d; x.e_tick = t;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t v, input int idx);
    rst            = v.rst;
    bus.ch_en      = v.en;
    bus.sync_in    = v.sync;
    bus.cfg_valid  = v.vld;
    bus.cfg_ch     = v.ch;
    bus.cfg_period = v.per;
    bus.cfg_high   = v.hi;
    #1;
    chk("cfg_ready", idx, 32'(bus.cfg_ready), 32'(v.e_rdy));
    @(posedge clk); #1;
    chk("div_clk", idx, 32'(bus.div_clk), 32'(v.e_div));
    chk("tick", idx, 32'(bus.tick), 32'(v.e_tick));
    @(negedge clk);
    bus.sync_in   = 1'b0;
    bus.cfg_valid = 1'b0;
  endtask

  // Default 100/50 waveform on one channel, starting at the edge that first samples ch_en.
  task automatic run_default(input int ch, input int n);
    logic [NCH-1:0] ed, et;
    bus.ch_en = NCH'(1) << ch;
    for (int k = 0; k < n; k++) begin
      ed = ((k % 100) < 50) ? (NCH'(1) << ch) : '0;
      et = ((k % 100) == 0) ? (NCH'(1) << ch) : '0;
      @(posedge clk); #1;
      chk("dflt_div", k, 32'(bus.div_clk), 32'(ed));
      chk("dflt_tick", k, 32'(bus.tick), 32'(et));
      @(negedge clk);
    end
    bus.ch_en = '0;
  endtask

  initial begin
    bus.ch_en = '0; bus.sync_in = 1'b0; bus.cfg_valid = 1'b0;
    bus.cfg_ch = '0; bus.cfg_period = '0; bus.cfg_high = '0;

    // ch1 P=10/H=3, reconfigured to 4/1 mid-period
    vq.push_back(mk(0, 6'b000000, 0, 1, 1, 10, 3, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000010, 6'b000010));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000010, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000010, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 1, 1,  4, 1, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 1, 1,  4, 1, 0, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 0, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 0, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 0, 6'b000010, 6'b000010));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000010, 6'b000010));
    vq.push_back(mk(0, 6'b000010, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000000, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));
    // ch2 P=1/H=0 (constant low, period 2) then P=7/H=7 (constant high)
    vq.push_back(mk(0, 6'b000000, 0, 1, 2,  1, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000100, 0, 0, 2,  0, 0, 1, 6'b000000, 6'b000100));
    vq.push_back(mk(0, 6'b000100, 0, 0, 2,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000100, 0, 0, 2,  0, 0, 1, 6'b000000, 6'b000100));
    vq.push_back(mk(0, 6'b000100, 0, 0, 2,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000000, 0, 0, 2,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000000, 0, 1, 2,  7, 7, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000100, 0, 0, 2,  0, 0, 1, 6'b000100, 6'b000100));
    for (int k = 1; k <= 6; k++)
      vq.push_back(mk(0, 6'b000100, 0, 0, 2, 0, 0, 1, 6'b000100, 6'b000000));
    vq.push_back(mk(0, 6'b000100, 0, 0, 2,  0, 0, 1, 6'b000100, 6'b000100));
    vq.push_back(mk(0, 6'b000000, 0, 0, 2,  0, 0, 1, 6'b000000, 6'b000000));
    // ch0 P=6/H=3, ch1 P=9/H=4, phase-aligned by sync_in
    vq.push_back(mk(0, 6'b000000, 0, 1, 0,  6, 3, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000000, 0, 1, 1,  9, 4, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000011, 6'b000011));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000011, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000011, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000010, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 1, 0, 0,  0, 0, 1, 6'b000011, 6'b000011));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000011, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000011, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000010, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000000, 6'b000000));
    // sync coincides with ch0's natural wrap: single tick
    vq.push_back(mk(0, 6'b000011, 1, 0, 0,  0, 0, 1, 6'b000011, 6'b000011));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000011, 6'b000000));
    // out-of-range channel writes are accepted and ignored
    vq.push_back(mk(0, 6'b000011, 0, 1, 7,  2, 1, 1, 6'b000011, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 6,  0, 0, 1, 6'b000010, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 0,  0, 0, 1, 6'b000001, 6'b000001));
    // reset while ch1 holds a pending shadow
    vq.push_back(mk(0, 6'b000011, 0, 1, 1,  3, 1, 1, 6'b000001, 6'b000000));
    vq.push_back(mk(0, 6'b000011, 0, 0, 1,  0, 0, 0, 6'b000001, 6'b000000));
    vq.push_back(mk(1, 6'b000011, 0, 0, 1,  0, 0, 0, 6'b000000, 6'b000000));
    vq.push_back(mk(0, 6'b000000, 0, 0, 1,  0, 0, 1, 6'b000000, 6'b000000));

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 0, 32'(bus.cfg_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_div", 0, 32'(bus.div_clk), 32'd0);
    chk("rst_tick", 0, 32'(bus.tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_default(0, 210);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // After reset ch1 must be back on 100/50 rather than 9/4 or 3/1
    run_default(1, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
